psg_dram_arbiter: RTL and testbench
===================================

# psg_dram_arbiter

Shares the single AXI-lite DRAM port (AR/R/AW/W/B channels of the `INF.DRAM` modport) between two internal requesters of the PSG design, e.g. the command-processing FSM and the write-back unit. It arbitrates round-robin, sequences each single-beat read or write transaction through the channel handshakes, and returns read data or write completion to the granted requester. Only one DRAM transaction is outstanding at a time.

## Interface
Parameters:
- `ADDR_W`, default 17: DRAM byte address width.
- `DATA_W`, default 64: DRAM word width.
- `N_REQ`, fixed 2: number of requesters. Not overridable.

Ports:
- `clk`  in  1  single clock
- `rst_n`  in  1  asynchronous active-low reset
- `req_valid`  in  2  per-requester request. Held high until the matching `resp_valid` pulse.
- `req_write`  in  2  1 = write, 0 = read.
- `req_addr`  in  2×ADDR_W  8-byte-aligned address, `[2:0]` = 0.
- `req_wdata`  in  2×DATA_W  write data.
- `resp_valid`  out  2  one-cycle completion pulse for the requester.
- `resp_rdata`  out  DATA_W  read data, valid with `resp_valid`.
- `resp_err`  out  1  1 if the DRAM RESP/BRESP of the transaction was nonzero.
- DRAM master side, AXI-lite naming:
  - out: `AR_VALID`, `AR_ADDR`[ADDR_W], `R_READY`, `AW_VALID`, `AW_ADDR`[ADDR_W], `W_VALID`, `W_DATA`[DATA_W], `B_READY`
  - in: `AR_READY`, `R_VALID`, `R_DATA`[DATA_W], `R_RESP`[2], `AW_READY`, `W_READY`, `B_VALID`, `B_RESP`[2]

## Operation
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, WR_RESP, DONE.
- **IDLE**
  - If any `req_valid` is high: grant one requester.
  - Latch its `write`, `addr` and `wdata` into internal registers.
  - Go to RD_ADDR (read) or WR_ADDR (write).
- **Arbitration**
  - With a single request, grant it.
  - With both high, grant the requester not served last.
  - `last_grant` resets to 1, so requester 0 wins the first tie.
  - `last_grant` updates on entry to DONE.
- **RD_ADDR**
  - `AR_VALID`=1, `AR_ADDR` = latched address.
  - On `AR_VALID && AR_READY`: drop `AR_VALID` and go to RD_DATA.
- **RD_DATA**
  - `R_READY`=1.
  - On `R_VALID`: capture `R_DATA` and `R_RESP` into the response registers, go to DONE.
- **WR_ADDR**
  - `AW_VALID`=1.
  - On `AW_READY`: go to WR_DATA.
- **WR_DATA**
  - `W_VALID`=1, `W_DATA` = latched data.
  - On `W_READY`: go to WR_RESP.
- **WR_RESP**
  - `B_READY`=1.
  - On `B_VALID`: capture `B_RESP`, go to DONE.
- **DONE**
  - `resp_valid[grant]`=1 for exactly one cycle.
  - `resp_rdata` holds the captured data (writes: previous value, don't-care).
  - `resp_err` = |RESP.
  - Go to IDLE.
- **Channel rules**
  - AW and W are issued sequentially, never concurrently.
  - A VALID, once asserted, holds its address/data stable and is never withdrawn before READY.
  - At most one of `AR_VALID`/`AW_VALID`/`W_VALID` is high in any cycle.
- **Requests during a transaction**: ignored. They are re-arbitrated in IDLE after DONE.
- **Requester handshake**: the requester deasserts `req_valid` in the cycle after `resp_valid`. A requester still high in IDLE after its own DONE is treated as a new request.

## Timing
- All outputs are registered.
- Reset values: FSM = IDLE; every VALID/READY output = 0; `AR_ADDR`, `AW_ADDR`, `W_DATA`, `resp_rdata` = 0; `resp_valid` = 0; `resp_err` = 0.
- Read latency: request seen in IDLE at cycle t gives `AR_VALID` at t+1.
  - With `AR_READY` and `R_VALID` each arriving in the first cycle they are waited on, `resp_valid` is at t+3.
  - Each extra DRAM wait cycle adds one cycle.
- Write latency, same zero-wait assumptions: `AW_VALID` at t+1, `W_VALID` at t+2, `B_READY` at t+3, `resp_valid` at t+4.
- Minimum spacing between consecutive DRAM transactions: 1 IDLE cycle.
- Reset asserted mid-transaction clears to the reset state immediately (asynchronously). No response is issued for the aborted request. The DRAM model shares `rst_n`.
- Back-pressure is unbounded: the FSM waits indefinitely on any channel.

## Structure
- Shared package (`usertype`):
  - `Dram_Addr` (17-bit) and `Dram_Data` (64-bit) typedefs.
  - `arb_state_t` enum for the FSM states.
  - `DRAM_BASE` = 17'h10000 constant.
- Sub-module `rr_arb2`: 2-way round-robin grant logic, combinational grant plus the `last_grant` register.
- Top-level target: about 200 lines.

## Test plan
- **Single read.** Req0 read, addr 17'h10008; DRAM returns 64'hDEAD_BEEF_0123_4567 with zero wait.
  - `AR_ADDR`=17'h10008 at t+1.
  - `resp_valid`=2'b01 at t+3, `resp_rdata` = 64'hDEAD_BEEF_0123_4567, `resp_err`=0.
- **Single write.** Req1 write, addr 17'h10010, data 64'h1.
  - AW, W, B appear in order, never overlapping.
  - `resp_valid`=2'b10 at t+4.
- **Tie after reset.** Both requesters request reads together right after reset.
  - Grant order is 0 then 1.
  - Both requesters hold: the next order is 0, 1, alternating.
- **DRAM wait states.** `AR_READY` delayed 5 cycles, `R_VALID` delayed 3 cycles.
  - `AR_VALID` and `AR_ADDR` stay stable throughout.
  - `resp_valid` at t+11.
- **Error response.** DRAM returns `B_RESP`=2'b10 on a write.
  - `resp_err`=1 with `resp_valid`.
  - The next clean read gives `resp_err`=0.
- **Reset mid-transaction.** `rst_n` pulsed low while in WR_DATA.
  - All outputs return to 0 within the same cycle.
  - No `resp_valid` is issued.
  - A fresh read after reset completes normally.

Source files
------------

// File: rtl/psg_dram_arbiter_pkg.sv
// Shared PSG types: DRAM word/address typedefs, arbiter FSM encoding and DRAM base address.
package usertype;

    typedef logic [16:0] Dram_Addr;
    typedef logic [63:0] Dram_Data;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR_ADDR = 3'd3,
        WR_DATA = 3'd4,
        WR_RESP = 3'd5,
        DONE    = 3'd6
    } arb_state_t;

    localparam Dram_Addr DRAM_BASE = 17'h10000;

endpackage

// File: rtl/psg_dram_arbiter_rr_arb2.sv
// Two-way round-robin grant: combinational pick plus the last-served register.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       update,
    input  logic       upd_idx,
    output logic       gnt_idx,
    output logic       any
);

    logic last_grant;

    assign any = |req;

    // On a tie the requester not served last wins; otherwise the lone requester.
    always_comb begin
        gnt_idx = req[1];
        if (req == 2'b11) gnt_idx = ~last_grant;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      last_grant <= 1'b1;
        else if (update) last_grant <= upd_idx;
    end

endmodule

// File: rtl/psg_dram_arbiter.sv
// Shares the single AXI-lite DRAM port between two requesters; one single-beat transaction at a time.
module psg_dram_arbiter
    import usertype::*;
#(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 64,
    localparam int N_REQ = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N_REQ-1:0]              req_valid,
    input  logic [N_REQ-1:0]              req_write,
    input  logic [N_REQ-1:0][ADDR_W-1:0]  req_addr,
    input  logic [N_REQ-1:0][DATA_W-1:0]  req_wdata,
    output logic [N_REQ-1:0]              resp_valid,
    output logic [DATA_W-1:0]             resp_rdata,
    output logic                          resp_err,
    output logic                          AR_VALID,
    output logic [ADDR_W-1:0]             AR_ADDR,
    output logic                          R_READY,
    output logic                          AW_VALID,
    output logic [ADDR_W-1:0]             AW_ADDR,
    output logic                          W_VALID,
    output logic [DATA_W-1:0]             W_DATA,
    output logic                          B_READY,
    input  logic                          AR_READY,
    input  logic                          R_VALID,
    input  logic [DATA_W-1:0]             R_DATA,
    input  logic [1:0]                    R_RESP,
    input  logic                          AW_READY,
    input  logic                          W_READY,
    input  logic                          B_VALID,
    input  logic [1:0]                    B_RESP
);

    arb_state_t state;
    logic       gnt_q;
    logic       gnt_idx;
    logic       any;
    logic       finish;

    // last_grant moves on the same edge that enters DONE.
    assign finish = (state == RD_DATA && R_VALID) || (state == WR_RESP && B_VALID);

    rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req_valid),
        .update  (finish),
        .upd_idx (gnt_q),
        .gnt_idx (gnt_idx),
        .any     (any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            gnt_q      <= 1'b0;
            resp_valid <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            AR_VALID   <= 1'b0;
            AR_ADDR    <= '0;
            R_READY    <= 1'b0;
            AW_VALID   <= 1'b0;
            AW_ADDR    <= '0;
            W_VALID    <= 1'b0;
            W_DATA     <= '0;
            B_READY    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (any) begin
                    gnt_q <= gnt_idx;
                    if (req_write[gnt_idx]) begin
                        AW_VALID <= 1'b1;
                        AW_ADDR  <= req_addr[gnt_idx];
                        W_DATA   <= req_wdata[gnt_idx];
                        state    <= WR_ADDR;
                    end else begin
                        AR_VALID <= 1'b1;
                        AR_ADDR  <= req_addr[gnt_idx];
                        state    <= RD_ADDR;
                    end
                end
                RD_ADDR: if (AR_READY) begin
                    AR_VALID <= 1'b0;
                    R_READY  <= 1'b1;
                    state    <= RD_DATA;
                end
                RD_DATA: if (R_VALID) begin
                    R_READY    <= 1'b0;
                    resp_rdata <= R_DATA;
                    resp_err   <= |R_RESP;
                    resp_valid <= 2'b01 << gnt_q;
                    state      <= DONE;
                end
                // W is only raised after AW has been accepted, so the two never overlap.
                WR_ADDR: if (AW_READY) begin
                    AW_VALID <= 1'b0;
                    W_VALID  <= 1'b1;
                    state    <= WR_DATA;
                end
                WR_DATA: if (W_READY) begin
                    W_VALID <= 1'b0;
                    B_READY <= 1'b1;
                    state   <= WR_RESP;
                end
                WR_RESP: if (B_VALID) begin
                    B_READY    <= 1'b0;
                    resp_err   <= |B_RESP;
                    resp_valid <= 2'b01 << gnt_q;
                    state      <= DONE;
                end
                DONE: begin
                    resp_valid <= '0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_psg_dram_arbiter.sv
// Directed bench for psg_dram_arbiter; the bench plays both requesters and the DRAM slave.
module tb_psg_dram_arbiter;
    import usertype::*;

    localparam int ADDR_W = 17;
    localparam int DATA_W = 64;

    logic                        clk = 1'b0;
    logic                        rst_n = 1'b0;
    logic [1:0]                  req_valid = '0;
    logic [1:0]                  req_write = '0;
    logic [1:0][ADDR_W-1:0]      req_addr = '0;
    logic [1:0][DATA_W-1:0]      req_wdata = '0;
    logic [1:0]                  resp_valid;
    logic [DATA_W-1:0]           resp_rdata;
    logic                        resp_err;
    logic                        AR_VALID, R_READY, AW_VALID, W_VALID, B_READY;
    logic [ADDR_W-1:0]           AR_ADDR, AW_ADDR;
    logic [DATA_W-1:0]           W_DATA;
    logic                        AR_READY = 1'b0, R_VALID = 1'b0, AW_READY = 1'b0;
    logic                        W_READY = 1'b0, B_VALID = 1'b0;
    logic [DATA_W-1:0]           R_DATA = '0;
    logic [1:0]                  R_RESP = '0, B_RESP = '0;

    int checks = 0;
    int errors = 0;

    psg_dram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .AR_VALID(AR_VALID), .AR_ADDR(AR_ADDR), .R_READY(R_READY),
        .AW_VALID(AW_VALID), .AW_ADDR(AW_ADDR), .W_VALID(W_VALID), .W_DATA(W_DATA), .B_READY(B_READY),
        .AR_READY(AR_READY), .R_VALID(R_VALID), .R_DATA(R_DATA), .R_RESP(R_RESP),
        .AW_READY(AW_READY), .W_READY(W_READY), .B_VALID(B_VALID), .B_RESP(B_RESP)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic all_zero(input string tag);
        chk({tag, "_valids"}, {AR_VALID, R_READY, AW_VALID, W_VALID, B_READY, resp_valid, resp_err}, 64'h0);
        chk({tag, "_addrs"}, {AR_ADDR, AW_ADDR}, 64'h0);
        chk({tag, "_wdata"}, W_DATA, 64'h0);
        chk({tag, "_rdata"}, resp_rdata, 64'h0);
    endtask

    // Single read by requester idx; ar_wait/r_wait = extra DRAM wait cycles on AR and R.
    task automatic do_read(input int idx, input logic [ADDR_W-1:0] addr, input logic [63:0] data,
                           input logic [1:0] rresp, input int ar_wait, input int r_wait);
        req_valid[idx] = 1'b1;
        req_write[idx] = 1'b0;
        req_addr[idx]  = addr;
        tick;
        chk("rd_chan_excl", {AR_VALID, AW_VALID, W_VALID}, 3'b100);
        for (int w = 0; w < ar_wait; w++) begin
            chk("rd_ar_hold", AR_VALID, 1'b1);
            chk("rd_ar_addr_hold", AR_ADDR, addr);
            tick;
        end
        chk("rd_ar_addr", AR_ADDR, addr);
        chk("rd_ar_valid", AR_VALID, 1'b1);
        AR_READY = 1'b1;
        tick;
        AR_READY = 1'b0;
        chk("rd_ar_drop", AR_VALID, 1'b0);
        for (int w = 0; w < r_wait; w++) begin
            chk("rd_r_ready_wait", R_READY, 1'b1);
            chk("rd_no_early_resp", resp_valid, 2'b00);
            tick;
        end
        chk("rd_r_ready", R_READY, 1'b1);
        R_VALID = 1'b1;
        R_DATA  = data;
        R_RESP  = rresp;
        tick;
        R_VALID = 1'b0;
        R_RESP  = 2'b00;
        chk("rd_resp_valid", resp_valid, (idx == 1) ? 2'b10 : 2'b01);
        chk("rd_resp_rdata", resp_rdata, data);
        chk("rd_resp_err", resp_err, |rresp);
        chk("rd_r_ready_drop", R_READY, 1'b0);
        tick;
        chk("rd_resp_pulse", resp_valid, 2'b00);
        req_valid[idx] = 1'b0;
    endtask

    task automatic do_write(input int idx, input logic [ADDR_W-1:0] addr, input logic [63:0] data,
                            input logic [1:0] bresp);
        req_valid[idx] = 1'b1;
        req_write[idx] = 1'b1;
        req_addr[idx]  = addr;
        req_wdata[idx] = data;
        tick;
        chk("wr_aw_only", {AR_VALID, AW_VALID, W_VALID, B_READY}, 4'b0100);
        chk("wr_aw_addr", AW_ADDR, addr);
        AW_READY = 1'b1;
        tick;
        AW_READY = 1'b0;
        chk("wr_w_only", {AR_VALID, AW_VALID, W_VALID, B_READY}, 4'b0010);
        chk("wr_w_data", W_DATA, data);
        W_READY = 1'b1;
        tick;
        W_READY = 1'b0;
        chk("wr_b_only", {AR_VALID, AW_VALID, W_VALID, B_READY}, 4'b0001);
        chk("wr_no_early_resp", resp_valid, 2'b00);
        B_VALID = 1'b1;
        B_RESP  = bresp;
        tick;
        B_VALID = 1'b0;
        B_RESP  = 2'b00;
        chk("wr_resp_valid", resp_valid, (idx == 1) ? 2'b10 : 2'b01);
        chk("wr_resp_err", resp_err, |bresp);
        chk("wr_b_ready_drop", B_READY, 1'b0);
        tick;
        chk("wr_resp_pulse", resp_valid, 2'b00);
        req_valid[idx] = 1'b0;
    endtask

    initial begin
        logic [ADDR_W-1:0] tie_addr [2];
        #1;
        all_zero("reset");
        tick;
        tick;
        rst_n = 1'b1;
        tick;
        all_zero("post_reset");

        // Tie straight after reset, both holding: grants 0,1,0,1.
        tie_addr[0] = DRAM_BASE + 17'h20;
        tie_addr[1] = DRAM_BASE + 17'h28;
        req_write = 2'b00;
        req_addr[0] = tie_addr[0];
        req_addr[1] = tie_addr[1];
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            tick;
            chk("tie_grant_addr", AR_ADDR, tie_addr[k % 2]);
            AR_READY = 1'b1;
            tick;
            AR_READY = 1'b0;
            R_VALID = 1'b1;
            R_DATA  = 64'h100 + 64'(k);
            tick;
            R_VALID = 1'b0;
            chk("tie_resp_valid", resp_valid, (k % 2 == 1) ? 2'b10 : 2'b01);
            chk("tie_resp_rdata", resp_rdata, 64'h100 + 64'(k));
            tick;
        end
        req_valid = 2'b00;
        tick;
        chk("tie_idle", {AR_VALID, AW_VALID}, 2'b00);

        do_read(0, DRAM_BASE + 17'h8, 64'hDEAD_BEEF_0123_4567, 2'b00, 0, 0);
        do_write(1, DRAM_BASE + 17'h10, 64'h1, 2'b00);
        do_read(1, DRAM_BASE + 17'h18, 64'hCAFE_F00D_8899_AABB, 2'b00, 5, 3);
        do_write(0, DRAM_BASE + 17'h30, 64'h5555_AAAA_5555_AAAA, 2'b10);
        do_read(0, DRAM_BASE + 17'h38, 64'h0BAD_F00D_1234_5678, 2'b00, 0, 0);

        // Reset pulsed while the write is in WR_DATA.
        req_valid[1] = 1'b1;
        req_write[1] = 1'b1;
        req_addr[1]  = DRAM_BASE + 17'h40;
        req_wdata[1] = 64'h7777_8888_9999_AAAA;
        tick;
        AW_READY = 1'b1;
        tick;
        AW_READY = 1'b0;
        chk("mid_in_wr_data", W_VALID, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        all_zero("mid_reset");
        req_valid = 2'b00;
        tick;
        tick;
        rst_n = 1'b1;
        tick;
        chk("mid_no_resp", resp_valid, 2'b00);
        chk("mid_idle", {AR_VALID, AW_VALID, W_VALID, B_READY}, 4'b0000);
        do_read(0, DRAM_BASE + 17'h48, 64'h1357_9BDF_2468_ACE0, 2'b00, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        errors++;
        $display("FAIL timeout observed running expected finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
